// File: rtl/sevenseg_scan_ctrl.sv
// Write-mapped scan controller for an 8-digit common-anode seven-segment display.
// Optional leading-zero blanking is built when SEVENSEG_LZB_EN is defined.
module sevenseg_scan_ctrl #(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    output logic [7:0]  catodes,
    output logic [7:0]  anodes
);

    localparam int unsigned TMAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] DIG_LAST = TW'(DIGIT_CYCLES - 1);
    localparam logic [TW-1:0] BLK_LAST = TW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        ADDR_VALUE  = 2'd0,
        ADDR_ENABLE = 2'd1,
        ADDR_DP     = 2'd2,
        ADDR_RSVD   = 2'd3
    } addr_e;

    typedef enum logic {
        ST_BLANK  = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    state_e        state_q,   state_d;
    logic [TW-1:0] timer_q,   timer_d;
    logic [2:0]    idx_q,     idx_d;
    logic [31:0]   value_q,   value_d;
    logic [7:0]    enable_q,  enable_d;
    logic [7:0]    dp_q,      dp_d;
    logic          wr_ready_q, wr_ready_d;
    logic [7:0]    anodes_q,  anodes_d;
    logic [7:0]    catodes_q, catodes_d;

    logic [3:0]    nibble;
    logic          lz_show;
    logic          digit_show;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        logic [7:0] seg;
        seg = 8'hFF;
        unique case (n)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    assign nibble = value_q[{idx_q, 2'b00} +: 4];

`ifdef SEVENSEG_LZB_EN
    // Digit 0 is never treated as a leading zero.
    assign lz_show = (idx_q == 3'd0) || ((value_q >> {idx_q, 2'b00}) != 32'd0);
`else
    assign lz_show = 1'b1;
`endif

    assign digit_show = enable_q[idx_q] && lz_show;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        value_d    = value_q;
        enable_d   = enable_q;
        dp_d       = dp_q;
        wr_ready_d = 1'b0;
        anodes_d   = anodes_q;
        catodes_d  = catodes_q;

        if (wr_en && !wr_ready_q) begin
            wr_ready_d = 1'b1;
            unique case (addr_e'(wr_addr))
                ADDR_VALUE:  value_d  = wr_data;
                ADDR_ENABLE: enable_d = wr_data[7:0];
                ADDR_DP:     dp_d     = wr_data[7:0];
                ADDR_RSVD:   ;
                default:     ;
            endcase
        end

        // Segment/anode content is captured from the pre-write registers on
        // ACTIVE entry and held unchanged for the whole digit.
        unique case (state_q)
            ST_BLANK: begin
                anodes_d  = '1;
                catodes_d = '1;
                if (timer_q == BLK_LAST) begin
                    state_d   = ST_ACTIVE;
                    timer_d   = '0;
                    anodes_d  = digit_show ? ~(8'b1 << idx_q) : 8'hFF;
                    catodes_d = hex7(nibble) & ~{dp_q[idx_q], 7'b0};
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (timer_q == DIG_LAST) begin
                    state_d   = ST_BLANK;
                    timer_d   = '0;
                    idx_d     = idx_q + 3'd1;
                    anodes_d  = '1;
                    catodes_d = '1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_BLANK;
                timer_d   = '0;
                anodes_d  = '1;
                catodes_d = '1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_BLANK;
            timer_q    <= '0;
            idx_q      <= '0;
            value_q    <= '0;
            enable_q   <= '1;
            dp_q       <= '0;
            wr_ready_q <= 1'b0;
            anodes_q   <= '1;
            catodes_q  <= '1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            value_q    <= value_d;
            enable_q   <= enable_d;
            dp_q       <= dp_d;
            wr_ready_q <= wr_ready_d;
            anodes_q   <= anodes_d;
            catodes_q  <= catodes_d;
        end
    end

    assign wr_ready = wr_ready_q;
    assign anodes   = anodes_q;
    assign catodes  = catodes_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with DIGIT_CYCLES=4, BLANK_CYCLES=2 (6-cycle slot, 48-cycle frame).
// Expectations follow SEVENSEG_LZB_EN when it is defined for the build.
module tb_sevenseg_scan_ctrl;

`ifdef SEVENSEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic [7:0]  catodes;
    logic [7:0]  anodes;

    int total;
    int bad;
    int cyc;

    sevenseg_scan_ctrl #(
        .DIGIT_CYCLES(4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_ready(wr_ready),
        .catodes (catodes),
        .anodes  (anodes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = edges since the last reset edge; digit (cyc/6)%8 is lit when cyc%6 >= 2.
    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto_raw(input int target);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((cyc % 48) != target && n < 200);
        if ((cyc % 48) != target) begin
            total++;
            bad++;
            $display("FAIL goto_slot got=%0d exp=%0d", cyc % 48, target);
        end
    endtask

    task automatic goto_digit(input int d, input int off);
        goto_raw(d * 6 + 2 + off);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] dat);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = dat;
        tick();
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL wr_ack got=%b exp=1 addr=%0d", wr_ready, a);
        end
        wr_en = 1'b0;
        tick();
        total++;
        if (wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL wr_ack_drop got=%b exp=0 addr=%0d", wr_ready, a);
        end
    endtask

    task automatic test_reset;
        logic [7:0] exp_d1;
        resetn  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        cyc = 0;
        total++;
        if (anodes !== 8'hFF || catodes !== 8'hFF || wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_state got=%h/%h/%b exp=ff/ff/0", anodes, catodes, wr_ready);
        end
        resetn = 1'b1;
        tick();
        total++;
        if (anodes !== 8'hFF) begin
            bad++;
            $display("FAIL rst_blank got=%h exp=ff", anodes);
        end
        tick();
        total++;
        if (anodes !== 8'hFE || catodes !== 8'hC0) begin
            bad++;
            $display("FAIL rst_d0_on got=%h/%h exp=fe/c0", anodes, catodes);
        end
        repeat (3) tick();
        total++;
        if (anodes !== 8'hFE || catodes !== 8'hC0) begin
            bad++;
            $display("FAIL rst_d0_hold got=%h/%h exp=fe/c0", anodes, catodes);
        end
        tick();
        total++;
        if (anodes !== 8'hFF || catodes !== 8'hFF) begin
            bad++;
            $display("FAIL rst_gap got=%h/%h exp=ff/ff", anodes, catodes);
        end
        tick();
        total++;
        if (anodes !== 8'hFF) begin
            bad++;
            $display("FAIL rst_gap2 got=%h exp=ff", anodes);
        end
        tick();
        exp_d1 = LZB ? 8'hFF : 8'hFD;
        total++;
        if (anodes !== exp_d1 || (!LZB && catodes !== 8'hC0)) begin
            bad++;
            $display("FAIL rst_d1 got=%h/%h exp=%h/c0", anodes, catodes, exp_d1);
        end
        goto_digit(0, 0);
        total++;
        if (anodes !== 8'hFE || catodes !== 8'hC0) begin
            bad++;
            $display("FAIL rst_wrap_d0 got=%h/%h exp=fe/c0", anodes, catodes);
        end
    endtask

    task automatic test_value;
        logic [7:0] ea [8];
        logic [7:0] ec [8];
        ea = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        ec = '{8'h8E, 8'hC6, 8'h83, 8'h88, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
        if (LZB) ea[7] = 8'hFF;
        do_write(2'd0, 32'h0123_ABCF);
        for (int d = 0; d < 8; d++) begin
            goto_digit(d, 0);
            total++;
            if (anodes !== ea[d]) begin
                bad++;
                $display("FAIL value_an d%0d got=%h exp=%h", d, anodes, ea[d]);
            end
            if (ea[d] != 8'hFF) begin
                total++;
                if (catodes !== ec[d]) begin
                    bad++;
                    $display("FAIL value_seg d%0d got=%h exp=%h", d, catodes, ec[d]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        wr_en   = 1'b1;
        wr_addr = 2'd3;
        wr_data = 32'hFFFF_FFFF;
        tick();
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ack1 got=%b exp=1", wr_ready);
        end
        tick();
        total++;
        if (wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_noreaccept got=%b exp=0", wr_ready);
        end
        tick();
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ack2 got=%b exp=1", wr_ready);
        end
        wr_en = 1'b0;
        tick();
        total++;
        if (wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drop got=%b exp=0", wr_ready);
        end
    endtask

    task automatic test_enable_dp;
        logic [7:0] ea [8];
        ea = '{8'hFE, 8'hFF, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_write(2'd1, 32'h0000_0005);
        do_write(2'd2, 32'h0000_0004);
        for (int d = 0; d < 8; d++) begin
            goto_digit(d, 1);
            total++;
            if (anodes !== ea[d]) begin
                bad++;
                $display("FAIL en_an d%0d got=%h exp=%h", d, anodes, ea[d]);
            end
            if (d == 0) begin
                total++;
                if (catodes !== 8'h8E) begin
                    bad++;
                    $display("FAIL en_seg d0 got=%h exp=8e", catodes);
                end
            end
            if (d == 2) begin
                total++;
                if (catodes !== 8'h03) begin
                    bad++;
                    $display("FAIL dp_seg d2 got=%h exp=03", catodes);
                end
            end
        end
        do_write(2'd1, 32'h0000_00FF);
    endtask

    task automatic test_simul_write;
        goto_raw(19);
        wr_en   = 1'b1;
        wr_addr = 2'd0;
        wr_data = 32'h7777_7777;
        tick();
        total++;
        if (wr_ready !== 1'b1 || anodes !== 8'hF7 || catodes !== 8'h88) begin
            bad++;
            $display("FAIL simul_d3 got=%b/%h/%h exp=1/f7/88", wr_ready, anodes, catodes);
        end
        wr_en = 1'b0;
        goto_raw(23);
        total++;
        if (anodes !== 8'hF7 || catodes !== 8'h88) begin
            bad++;
            $display("FAIL simul_d3_hold got=%h/%h exp=f7/88", anodes, catodes);
        end
        goto_digit(4, 0);
        total++;
        if (anodes !== 8'hEF || catodes !== 8'hF8) begin
            bad++;
            $display("FAIL simul_d4 got=%h/%h exp=ef/f8", anodes, catodes);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] exp_an;
        do_write(2'd1, 32'h0000_0005);
        goto_digit(1, 1);
        wr_en   = 1'b1;
        wr_addr = 2'd0;
        wr_data = 32'h0000_0009;
        resetn  = 1'b0;
        tick();
        cyc = 0;
        total++;
        if (anodes !== 8'hFF || catodes !== 8'hFF || wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL midrst_state got=%h/%h/%b exp=ff/ff/0", anodes, catodes, wr_ready);
        end
        resetn = 1'b1;
        tick();
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_reaccept got=%b exp=1", wr_ready);
        end
        wr_en = 1'b0;
        tick();
        total++;
        if (anodes !== 8'hFE || catodes !== 8'h90) begin
            bad++;
            $display("FAIL midrst_d0 got=%h/%h exp=fe/90", anodes, catodes);
        end
        goto_digit(1, 0);
        exp_an = LZB ? 8'hFF : 8'hFD;
        total++;
        if (anodes !== exp_an || (!LZB && catodes !== 8'hC0)) begin
            bad++;
            $display("FAIL midrst_d1 got=%h/%h exp=%h/c0", anodes, catodes, exp_an);
        end
        goto_digit(2, 0);
        exp_an = LZB ? 8'hFF : 8'hFB;
        total++;
        if (anodes !== exp_an || (!LZB && catodes !== 8'hC0)) begin
            bad++;
            $display("FAIL midrst_d2 got=%h/%h exp=%h/c0", anodes, catodes, exp_an);
        end
    endtask

    task automatic test_lzb;
        logic [7:0] ea [8];
        ea = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        if (LZB) begin
            for (int d = 2; d < 8; d++) ea[d] = 8'hFF;
        end
        do_write(2'd0, 32'h0000_00A0);
        for (int d = 0; d < 8; d++) begin
            goto_digit(d, 2);
            total++;
            if (anodes !== ea[d]) begin
                bad++;
                $display("FAIL lzb_an d%0d got=%h exp=%h", d, anodes, ea[d]);
            end
            if (d < 3 && ea[d] != 8'hFF) begin
                total++;
                if (catodes !== ((d == 1) ? 8'h88 : 8'hC0)) begin
                    bad++;
                    $display("FAIL lzb_seg d%0d got=%h exp=%h", d, catodes, (d == 1) ? 8'h88 : 8'hC0);
                end
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        resetn  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = '0;
        test_reset();
        test_value();
        test_back_to_back();
        test_enable_dp();
        test_simul_write();
        test_reset_mid();
        test_lzb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
